// File: rtl/fetch_pc_if.sv
// Bundle of fetch, predictor, resolve and training signals around the fetch PC unit.
// The master modport is the PC unit. The slave modport is the surrounding pipeline.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

interface fetch_pc_if #(
  parameter int PC_W = `PC_SIZE
);
  logic [PC_W-1:0] pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            fetch_valid;
  logic            fetch_ready;
  logic            res_valid;
  logic            res_is_branch;
  logic            res_taken;
  logic [PC_W-1:0] res_target;
  logic            flush;
  logic            fb_valid;
  logic [PC_W-1:0] fb_pc;
  logic            fb_taken;
  logic [PC_W-1:0] fb_target;
  logic            fb_mispredict;
  logic            q_err;

  modport master (
    output pc, fetch_valid, flush, fb_valid, fb_pc, fb_taken, fb_target, fb_mispredict, q_err,
    input  pred_taken, pred_target, fetch_ready, res_valid, res_is_branch, res_taken, res_target
  );

  modport slave (
    input  pc, fetch_valid, flush, fb_valid, fb_pc, fb_taken, fb_target, fb_mispredict, q_err,
    output pred_taken, pred_target, fetch_ready, res_valid, res_is_branch, res_taken, res_target
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator. It keeps an in-order queue of predictions and checks them against execute resolutions.
// On a mispredict it redirects the PC and flushes. It also produces one registered training record per trained resolve.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module fetch_pc_unit #(
  parameter int              PC_W     = `PC_SIZE,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 1,
  parameter int              Q_DEPTH  = 4
) (
  input logic       clk,
  input logic       n_rst,
  fetch_pc_if.master bus
);
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  pc_r;
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  q_pc     [Q_DEPTH];
  logic             q_taken  [Q_DEPTH];
  logic [PC_W-1:0]  q_target [Q_DEPTH];

  logic            fb_valid_r, fb_taken_r, fb_mis_r, q_err_r;
  logic [PC_W-1:0] fb_pc_r, fb_target_r;

  logic            res_fire, actual_taken, mispredict, fetch_valid, fire;
  logic [PC_W-1:0] h_pc, h_target;
  logic            h_taken;

  always_comb begin
    h_pc         = q_pc[head];
    h_taken      = q_taken[head];
    h_target     = q_target[head];
    res_fire     = bus.res_valid & (count != '0);
    actual_taken = bus.res_is_branch & bus.res_taken;
    mispredict   = res_fire & ((actual_taken != h_taken) |
                               (actual_taken & (bus.res_target != h_target)));
    // A mispredict kills the offer in the same cycle, so a flush never coincides with a push.
    fetch_valid  = n_rst & (count != CNT_W'(Q_DEPTH)) & ~mispredict;
    fire         = fetch_valid & bus.fetch_ready;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      pc_r  <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mispredict) begin
      pc_r  <= actual_taken ? bus.res_target : h_pc + PC_W'(PC_INC);
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fire) begin
        q_pc[tail]     <= pc_r;
        q_taken[tail]  <= bus.pred_taken;
        q_target[tail] <= bus.pred_target;
        tail           <= tail + PTR_W'(1);
        pc_r           <= bus.pred_taken ? bus.pred_target : pc_r + PC_W'(PC_INC);
      end
      if (res_fire) head <= head + PTR_W'(1);
      if (fire && !res_fire)      count <= count + CNT_W'(1);
      else if (!fire && res_fire) count <= count - CNT_W'(1);
    end
  end

  // Non-branches train only when they were predicted taken, to pull the predictor back toward not-taken.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fb_valid_r  <= 1'b0;
      fb_pc_r     <= '0;
      fb_taken_r  <= 1'b0;
      fb_target_r <= '0;
      fb_mis_r    <= 1'b0;
      q_err_r     <= 1'b0;
    end else begin
      fb_valid_r <= 1'b0;
      if (res_fire && (bus.res_is_branch || mispredict)) begin
        fb_valid_r  <= 1'b1;
        fb_pc_r     <= h_pc;
        fb_taken_r  <= actual_taken;
        fb_target_r <= bus.res_target;
        fb_mis_r    <= mispredict;
      end
      if (bus.res_valid && count == '0) q_err_r <= 1'b1;
    end
  end

  assign bus.pc            = pc_r;
  assign bus.fetch_valid   = fetch_valid;
  assign bus.flush         = n_rst & mispredict;
  assign bus.fb_valid      = fb_valid_r;
  assign bus.fb_pc         = fb_pc_r;
  assign bus.fb_taken      = fb_taken_r;
  assign bus.fb_target     = fb_target_r;
  assign bus.fb_mispredict = fb_mis_r;
  assign bus.q_err         = q_err_r;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit. A queue-based reference model predicts pc, fetch_valid, flush and q_err.
// Expected training records are queued by the driver and popped by an independent monitor.
module tb_fetch_pc_unit;
  localparam int              PC_W     = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam int              Q_DEPTH  = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } ent_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
    logic            mis;
  } fb_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  fetch_pc_if #(.PC_W(PC_W)) bus ();

  fetch_pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .PC_INC(1), .Q_DEPTH(Q_DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ent_t            ftq[$];
  fb_t             fbq[$];
  logic [PC_W-1:0] m_pc = RESET_PC;
  logic            m_qerr = 1'b0;
  logic            fb_due = 1'b0;

  task automatic checkOutput(input string name, input logic [PC_W-1:0] actual, input logic [PC_W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The monitor consumes one expected training record each time the DUT presents fb_valid.
  always @(posedge clk) begin
    #1;
    if (bus.fb_valid === 1'b1) begin
      if (fbq.size() == 0) begin
        checkOutput("fb_valid_unexpected", bus.fb_valid, 1'b0);
      end else begin
        fb_t e;
        e = fbq.pop_front();
        checkOutput("fb_pc", bus.fb_pc, e.pc);
        checkOutput("fb_taken", PC_W'(bus.fb_taken), PC_W'(e.taken));
        checkOutput("fb_target", bus.fb_target, e.target);
        checkOutput("fb_mispredict", PC_W'(bus.fb_mispredict), PC_W'(e.mis));
      end
    end
  end

  task automatic applyStimulus(input logic rst_n, input logic rdy, input logic pt, input logic [PC_W-1:0] ptg,
                               input logic rv, input logic rb, input logic rt, input logic [PC_W-1:0] rtg);
    logic exp_fv, exp_flush, res_ok, at, mis, fire;
    ent_t h;
    @(negedge clk);
    if (fb_due) checkOutput("fb_delivered", PC_W'(fbq.size()), '0);
    fb_due = 1'b0;
    n_rst = rst_n;
    bus.fetch_ready = rdy;
    bus.pred_taken = pt;
    bus.pred_target = ptg;
    bus.res_valid = rv;
    bus.res_is_branch = rb;
    bus.res_taken = rt;
    bus.res_target = rtg;
    #1;
    if (!rst_n) begin
      checkOutput("fetch_valid_rst", PC_W'(bus.fetch_valid), '0);
      checkOutput("flush_rst", PC_W'(bus.flush), '0);
      ftq.delete();
      m_pc = RESET_PC;
      m_qerr = 1'b0;
      return;
    end
    res_ok = rv && ftq.size() > 0;
    at = rb && rt;
    mis = 1'b0;
    h = '0;
    if (res_ok) begin
      h = ftq[0];
      mis = (at != h.taken) || (at && rtg != h.target);
    end
    exp_flush = mis;
    exp_fv = (ftq.size() < Q_DEPTH) && !mis;
    checkOutput("pc", bus.pc, m_pc);
    checkOutput("fetch_valid", PC_W'(bus.fetch_valid), PC_W'(exp_fv));
    checkOutput("flush", PC_W'(bus.flush), PC_W'(exp_flush));
    checkOutput("q_err", PC_W'(bus.q_err), PC_W'(m_qerr));
    fire = exp_fv && rdy;
    if (rv && ftq.size() == 0) m_qerr = 1'b1;
    if (res_ok && (rb || mis)) begin
      fbq.push_back('{pc: h.pc, taken: at, target: rtg, mis: mis});
      fb_due = 1'b1;
    end
    if (mis) begin
      m_pc = at ? rtg : h.pc + 1;
      ftq.delete();
    end else begin
      if (res_ok) void'(ftq.pop_front());
      if (fire) begin
        ftq.push_back('{pc: m_pc, taken: pt, target: ptg});
        m_pc = pt ? ptg : m_pc + 1;
      end
    end
  endtask

  initial begin
    logic rst_n, rdy, pt, rv, rb, rt;
    logic [PC_W-1:0] ptg, rtg;
    ent_t h;
    bus.fetch_ready = 1'b0; bus.pred_taken = 1'b0; bus.pred_target = '0;
    bus.res_valid = 1'b0; bus.res_is_branch = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // Sequential fetch, then a taken prediction from pc 3 to 0x40 and a correct resolve of pc 0.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 32'h40, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 0);
    // Fill the queue past capacity, then resolve correctly so exactly one more push fits.
    for (int i = 0; i < Q_DEPTH + 2; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    // pc 2 was fetched not-taken, so resolving it taken to 0x20 must flush.
    applyStimulus(1, 1, 0, 0, 1, 1, 1, 32'h20);
    applyStimulus(1, 1, 1, 32'h10, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      pt = ($urandom_range(0, 2) == 0);
      ptg = PC_W'($urandom_range(0, 63));
      rv = ($urandom_range(0, 2) == 0);
      rb = $urandom_range(0, 1) == 1;
      rt = $urandom_range(0, 1) == 1;
      rtg = PC_W'($urandom_range(0, 63));
      if (ftq.size() > 0 && $urandom_range(0, 2) != 0) begin
        h = ftq[0];
        if (h.taken) begin
          rb = 1'b1; rt = 1'b1; rtg = h.target;
        end else if (rb) begin
          rt = 1'b0;
        end
      end
      applyStimulus(rst_n, rdy, pt, ptg, rv, rb, rt, rtg);
    end

    @(negedge clk);
    if (fb_due) checkOutput("fb_delivered", PC_W'(fbq.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
